// File: rtl/readout_sequencer.sv
// Pixel-row readout sequencer: walks rows, holds each NRE low through settle and one ADC conversion.
// Optional READOUT_ERASE_EN adds an Erase pulse after each completed frame.
module readout_sequencer #(
  parameter int unsigned NUM_ROWS      = 2,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ADC_TIMEOUT   = 8,
  parameter int unsigned ERASE_CYCLES  = 3
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Abort,
  input  logic                Adc_done,
  output logic                Adc_start,
  output logic [NUM_ROWS-1:0] NRE,
  output logic [3:0]          Row_idx,
  output logic                Busy,
  output logic                Frame_done,
  output logic                Timeout_err,
  output logic                Erase
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StSelect  = 3'd1;
  localparam logic [2:0] StConvert = 3'd2;
  localparam logic [2:0] StNext    = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;
`ifdef READOUT_ERASE_EN
  localparam logic [2:0] StErase   = 3'd5;
`endif

  localparam logic [3:0] SettleLast  = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] TimeoutLast = 8'(ADC_TIMEOUT - 1);
  localparam logic [3:0] RowLast     = 4'(NUM_ROWS - 1);

  logic [2:0]          state_q, state_d;
  logic [3:0]          row_d;
  logic [3:0]          settle_q, settle_d;
  logic [7:0]          wait_q, wait_d;
  logic                timeout_err_d;
  logic                adc_start_d;
  logic [NUM_ROWS-1:0] nre_d;
`ifdef READOUT_ERASE_EN
  localparam logic [7:0] EraseLast = 8'(ERASE_CYCLES - 1);
  logic [7:0]          erase_cnt_q, erase_cnt_d;
`endif

  always_comb begin
    state_d       = state_q;
    row_d         = Row_idx;
    settle_d      = settle_q;
    wait_d        = wait_q;
    timeout_err_d = Timeout_err;
`ifdef READOUT_ERASE_EN
    erase_cnt_d   = erase_cnt_q;
`endif
    // Abort outranks every other event once a readout is in flight.
    if (state_q != StIdle && Abort) begin
      state_d  = StIdle;
      row_d    = 4'd0;
      settle_d = 4'd0;
      wait_d   = 8'd0;
`ifdef READOUT_ERASE_EN
      erase_cnt_d = 8'd0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (Start) begin
            state_d       = StSelect;
            row_d         = 4'd0;
            settle_d      = 4'd0;
            timeout_err_d = 1'b0;
          end
        end
        StSelect: begin
          if (settle_q == SettleLast) begin
            state_d  = StConvert;
            settle_d = 4'd0;
            wait_d   = 8'd0;
          end else begin
            settle_d = settle_q + 4'd1;
          end
        end
        StConvert: begin
          // wait_q is zero in the Adc_start cycle, so a done there is ignored.
          if (wait_q != 8'd0 && Adc_done) begin
            state_d = StNext;
            wait_d  = 8'd0;
          end else if (wait_q == TimeoutLast) begin
            state_d       = StNext;
            wait_d        = 8'd0;
            timeout_err_d = 1'b1;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
        StNext: begin
          if (Row_idx == RowLast) begin
            state_d = StDone;
          end else begin
            state_d  = StSelect;
            row_d    = Row_idx + 4'd1;
            settle_d = 4'd0;
          end
        end
        StDone: begin
          row_d = 4'd0;
`ifdef READOUT_ERASE_EN
          state_d     = StErase;
          erase_cnt_d = 8'd0;
`else
          state_d = StIdle;
`endif
        end
`ifdef READOUT_ERASE_EN
        StErase: begin
          if (erase_cnt_q == EraseLast) begin
            state_d     = StIdle;
            erase_cnt_d = 8'd0;
          end else begin
            erase_cnt_d = erase_cnt_q + 8'd1;
          end
        end
`endif
        default: begin
          state_d = StIdle;
          row_d   = 4'd0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they can be registered alongside it.
  always_comb begin
    nre_d = '1;
    if (state_d == StSelect || state_d == StConvert) begin
      for (int unsigned i = 0; i < NUM_ROWS; i++) begin
        if (row_d == 4'(i)) nre_d[i] = 1'b0;
      end
    end
    adc_start_d = (state_q == StSelect) && (state_d == StConvert);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= StIdle;
      settle_q    <= 4'd0;
      wait_q      <= 8'd0;
      Row_idx     <= 4'd0;
      NRE         <= '1;
      Adc_start   <= 1'b0;
      Busy        <= 1'b0;
      Frame_done  <= 1'b0;
      Timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      wait_q      <= wait_d;
      Row_idx     <= row_d;
      NRE         <= nre_d;
      Adc_start   <= adc_start_d;
      Busy        <= (state_d != StIdle);
      Frame_done  <= (state_d == StDone);
      Timeout_err <= timeout_err_d;
    end
  end

`ifdef READOUT_ERASE_EN
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      erase_cnt_q <= 8'd0;
      Erase       <= 1'b0;
    end else begin
      erase_cnt_q <= erase_cnt_d;
      Erase       <= (state_d == StErase);
    end
  end
`else
  assign Erase = 1'b0;
`endif

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed self-checking bench for readout_sequencer (default parameters, NUM_ROWS=2, SETTLE=2).
module tb_readout_sequencer;

  logic       Clk = 1'b0;
  logic       Reset, Start, Abort, Adc_done;
  logic       Adc_start, Busy, Frame_done, Timeout_err, Erase;
  logic [1:0] NRE;
  logic [3:0] Row_idx;

  int checks = 0;
  int errors = 0;

  // ADC model state: answers one cycle after it sees Adc_start.
  logic adc_auto   = 1'b1;
  logic mute_row0  = 1'b0;
  logic start_seen = 1'b0;

`ifdef READOUT_ERASE_EN
  localparam int FrameBusy = 14;
`else
  localparam int FrameBusy = 11;
`endif

  readout_sequencer dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Abort      (Abort),
    .Adc_done   (Adc_done),
    .Adc_start  (Adc_start),
    .NRE        (NRE),
    .Row_idx    (Row_idx),
    .Busy       (Busy),
    .Frame_done (Frame_done),
    .Timeout_err(Timeout_err),
    .Erase      (Erase)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed no_finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
    if (adc_auto) begin
      Adc_done   = start_seen && !(mute_row0 && Row_idx == 4'd0);
      start_seen = Adc_start;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] nom_nre(input int n);
    if (n <= 4) return 2'b10;
    if (n == 5) return 2'b11;
    if (n <= 9) return 2'b01;
    return 2'b11;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_nre"}, 32'(NRE), 32'h3);
    chk({tag, "_adc_start"}, 32'(Adc_start), 32'h0);
    chk({tag, "_row"}, 32'(Row_idx), 32'h0);
    chk({tag, "_busy"}, 32'(Busy), 32'h0);
    chk({tag, "_frame_done"}, 32'(Frame_done), 32'h0);
    chk({tag, "_timeout_err"}, 32'(Timeout_err), 32'h0);
    chk({tag, "_erase"}, 32'(Erase), 32'h0);
  endtask

  task automatic run_nominal(input string tag);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      chk({tag, "_nre"}, 32'(NRE), 32'(nom_nre(n)));
      chk({tag, "_adc_start"}, 32'(Adc_start), 32'(n == 3 || n == 8));
      chk({tag, "_frame_done"}, 32'(Frame_done), 32'(n == 11));
      chk({tag, "_busy"}, 32'(Busy), 32'h1);
      chk({tag, "_row"}, 32'(Row_idx), 32'(n >= 6));
      tick();
    end
`ifdef READOUT_ERASE_EN
    for (int n = 12; n <= 14; n++) begin
      chk({tag, "_erase_on"}, 32'(Erase), 32'h1);
      chk({tag, "_erase_nre"}, 32'(NRE), 32'h3);
      chk({tag, "_erase_busy"}, 32'(Busy), 32'h1);
      tick();
    end
`endif
    chk({tag, "_busy_fall"}, 32'(Busy), 32'h0);
    chk({tag, "_erase_off"}, 32'(Erase), 32'h0);
    chk({tag, "_idle_nre"}, 32'(NRE), 32'h3);
  endtask

  initial begin
    int fd_count;
    int bound;
    Reset = 1'b0; Start = 1'b0; Abort = 1'b0; Adc_done = 1'b0;
    tick();
    Reset = 1'b1;
    chk_reset_vals("reset");
    tick();

    // Nominal frame.
    run_nominal("nom");

    // Row 0 times out; row 1 is still read.
    mute_row0 = 1'b1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      if (n == 10) begin
        chk("to_err_before", 32'(Timeout_err), 32'h0);
        chk("to_nre_convert", 32'(NRE), 32'h2);
      end
      if (n == 11) begin
        chk("to_err_set", 32'(Timeout_err), 32'h1);
        chk("to_nre_next", 32'(NRE), 32'h3);
      end
      if (n == 12) begin
        chk("to_row1", 32'(Row_idx), 32'h1);
        chk("to_row1_nre", 32'(NRE), 32'h1);
      end
      if (n == 14) chk("to_row1_adc_start", 32'(Adc_start), 32'h1);
      if (n == 17) begin
        chk("to_frame_done", 32'(Frame_done), 32'h1);
        chk("to_err_held", 32'(Timeout_err), 32'h1);
      end
      tick();
    end
    mute_row0 = 1'b0;
    bound = 0;
    while (Busy && bound < 10) begin
      tick();
      bound++;
    end
    chk("to_busy_fall", 32'(Busy), 32'h0);
    tick(); tick();
    chk("to_err_sticky_idle", 32'(Timeout_err), 32'h1);

    // Abort in IDLE is a no-op, so Start is still taken; then abort row 1 with Adc_done.
    Abort = 1'b1; Start = 1'b1;
    tick();
    Abort = 1'b0; Start = 1'b0;
    chk("ab_start_busy", 32'(Busy), 32'h1);
    chk("ab_start_nre", 32'(NRE), 32'h2);
    chk("ab_err_cleared", 32'(Timeout_err), 32'h0);
    for (int n = 1; n < 9; n++) tick();
    chk("ab_convert_nre", 32'(NRE), 32'h1);
    chk("ab_adc_done_present", 32'(Adc_done), 32'h1);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("ab_nre", 32'(NRE), 32'h3);
    chk("ab_busy", 32'(Busy), 32'h0);
    chk("ab_row", 32'(Row_idx), 32'h0);
    chk("ab_adc_start", 32'(Adc_start), 32'h0);
    fd_count = 0;
    for (int n = 0; n < 12; n++) begin
      fd_count += int'(Frame_done);
      tick();
    end
    chk("ab_no_frame_done", 32'(fd_count), 32'h0);
    chk("ab_still_idle", 32'(Busy), 32'h0);
    run_nominal("ab_rerun");

    // Start held high for 20 cycles: two frames, one idle cycle between them.
    fd_count = 0;
    Start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      fd_count += int'(Frame_done);
      if (c == FrameBusy + 1) chk("hold_idle_gap", 32'(Busy), 32'h0);
      if (c == FrameBusy + 2) begin
        chk("hold_second_busy", 32'(Busy), 32'h1);
        chk("hold_second_nre", 32'(NRE), 32'h2);
      end
    end
    Start = 1'b0;
    bound = 0;
    while (Busy && bound < 40) begin
      tick();
      fd_count += int'(Frame_done);
      bound++;
    end
    chk("hold_busy_fall", 32'(Busy), 32'h0);
    chk("hold_frame_count", 32'(fd_count), 32'h2);
    tick();
    chk("hold_stays_idle", 32'(Busy), 32'h0);

    // Reset while selecting row 1 with Timeout_err set.
    mute_row0 = 1'b1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int n = 1; n < 12; n++) tick();
    mute_row0 = 1'b0;
    chk("rst_pre_err", 32'(Timeout_err), 32'h1);
    chk("rst_pre_nre", 32'(NRE), 32'h1);
    chk("rst_pre_row", 32'(Row_idx), 32'h1);
    Reset = 1'b0;
    adc_auto = 1'b0;
    tick();
    chk_reset_vals("rst_mid");
    Adc_done = 1'b1;
    tick();
    Adc_done = 1'b0;
    tick();
    Adc_done = 1'b1;
    tick();
    chk_reset_vals("rst_adc_pulses");
    Reset = 1'b1;
    tick();
    Adc_done = 1'b0;
    chk_reset_vals("rst_release");
    tick();
    chk_reset_vals("rst_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
